// File: rtl/flit_requester.sv
// Buffers upstream flits, arbitrates for the output with a registered request, and forwards one packet per grant.
// Optional starvation monitor enabled by defining FLIT_REQUESTER_STARVE_MONITOR_EN.
//
// state  | meaning
// IDLE   | waiting for a packet-start flit at the FIFO head; stray body/tail flits are dropped
// REQ    | request_o asserted, waiting for grant_i
// XFER   | output owned; flits forwarded until a tail or head-tail is accepted
module flit_requester #(
  parameter int FLIT_WIDTH   = 34,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [FLIT_WIDTH-1:0] in_flit_i,
  output logic                  in_ready_o,
  output logic                  request_o,
  input  logic                  grant_i,
  output logic                  out_valid_o,
  output logic [FLIT_WIDTH-1:0] out_flit_o,
  input  logic                  out_ready_i,
  output logic                  release_o,
  output logic                  drop_o,
  output logic                  starve_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  logic [FLIT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  state_t                r_state;
  logic                  r_request;

  logic                  w_empty;
  logic                  w_full;
  logic [1:0]            w_head_type;
  logic                  w_head_starts;
  logic                  w_head_ends;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_fwd;
  logic                  w_pop;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == DEPTH_C);
  assign w_head_type   = r_mem[r_rptr][FLIT_WIDTH-1 -: 2];
  // head (00) and head-tail (11) open a packet; tail (10) and head-tail close one
  assign w_head_starts = (w_head_type == 2'b00) || (w_head_type == 2'b11);
  assign w_head_ends   = w_head_type[1];

  assign w_push = in_valid_i && !w_full;
  assign w_drop = (r_state == S_IDLE) && !w_empty && !w_head_starts;
  assign w_fwd  = (r_state == S_XFER) && !w_empty && out_ready_i;
  assign w_pop  = w_drop || w_fwd;

  assign in_ready_o  = !w_full;
  assign request_o   = r_request;
  assign out_valid_o = (r_state == S_XFER) && !w_empty;
  assign out_flit_o  = r_mem[r_rptr];
  assign release_o   = w_fwd && w_head_ends;
  assign drop_o      = w_drop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_flit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_request <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty && w_head_starts) begin
            r_state   <= S_REQ;
            r_request <= 1'b1;
          end
        end
        S_REQ: begin
          if (grant_i) begin
            r_state   <= S_XFER;
            r_request <= 1'b0;
          end
        end
        S_XFER: begin
          if (w_fwd && w_head_ends) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_request <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLIT_REQUESTER_STARVE_MONITOR_EN
  localparam int WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] r_wait;

  // saturates while ungranted in REQ; any other cycle clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if ((r_state == S_REQ) && !grant_i) begin
      if (r_wait != LIMIT_C) r_wait <= r_wait + 1'b1;
    end else begin
      r_wait <= '0;
    end
  end

  assign starve_o = (r_wait == LIMIT_C);
`else
  assign starve_o = 1'b0;
`endif

endmodule
